// File: rtl/unified_mem_scheduler.sv
// Shared I/D memory port arbiter: one req/ack transaction at a time, read data routed to its owner.
// Latency: gnt at T, mem_req from T+1, rvalid at ack+1; a request arriving while busy waits (no gnt).
module unified_mem_scheduler #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15,
   parameter int FAIR     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [DATA_W-1:0]     dm_wdata,
   input  logic [DATA_W/8-1:0]   dm_be,
   output logic                  dm_gnt,
   output logic                  dm_rvalid,
   output logic [DATA_W-1:0]     dm_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  stall_pc,
   output logic                  err_timeout
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

   state_t           state;
   logic             last_dm;
   logic [CNT_W-1:0] wait_cnt;
   logic             pick_dm;
   logic             pick_if;
   logic             timeout;

   // Grants are combinational so the requester sees acceptance in the cycle it asks.
   always_comb begin
      pick_dm = 1'b0;
      pick_if = 1'b0;
      if (!rst && state == IDLE) begin
         if (dm_req && if_req) begin
            pick_dm = (FAIR != 0) ? !last_dm : 1'b1;
            pick_if = !pick_dm;
         end else begin
            pick_dm = dm_req;
            pick_if = if_req;
         end
      end
   end

   assign if_gnt   = pick_if;
   assign dm_gnt   = pick_dm;
   assign stall_pc = !rst && (dm_req || state == DM_BUSY || dm_rvalid);
   // A late ack on the final allowed cycle still completes normally.
   assign timeout  = (state != IDLE) && !mem_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_dm     <= 1'b0;
         wait_cnt    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         if_rvalid   <= 1'b0;
         if_rdata    <= '0;
         dm_rvalid   <= 1'b0;
         dm_rdata    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if_rvalid   <= 1'b0;
         dm_rvalid   <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (pick_dm) begin
                  state     <= DM_BUSY;
                  last_dm   <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_be    <= dm_be;
               end else if (pick_if) begin
                  state     <= IF_BUSY;
                  last_dm   <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_be    <= '0;
               end
            end
            IF_BUSY, DM_BUSY: begin
               if (mem_ack || timeout) begin
                  state       <= IDLE;
                  mem_req     <= 1'b0;
                  wait_cnt    <= '0;
                  err_timeout <= !mem_ack;
                  if (state == DM_BUSY) begin
                     dm_rvalid <= 1'b1;
                     dm_rdata  <= (mem_ack && !mem_we) ? mem_rdata : '0;
                  end else begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_ack ? mem_rdata : '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_unified_mem_scheduler.sv
// Bench for unified_mem_scheduler: FAIR=1 instance with a programmable-latency memory,
// plus a FAIR=0 instance with a fixed one-cycle memory for the priority check.
module tb_unified_mem_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [3:0]  dm_be = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack_0 = 1'b0;
   logic [31:0] mem_rdata_0 = '0;

   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, stall_pc, err_timeout;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        if_gnt_0, if_rvalid_0, dm_gnt_0, dm_rvalid_0, mem_req_0, mem_we_0, stall_pc_0, err_timeout_0;
   logic [31:0] if_rdata_0, dm_rdata_0, mem_addr_0, mem_wdata_0;
   logic [3:0]  mem_be_0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [32:0] q_if[$];
   logic [32:0] q_dm[$];

   int          ack_lat = 1;
   bit          no_ack = 1'b1;
   logic [31:0] rdata_next = '0;
   int          bcyc = 0;

   always #5 clk = ~clk;

   unified_mem_scheduler #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .FAIR(1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_pc(stall_pc), .err_timeout(err_timeout)
   );

   unified_mem_scheduler #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .FAIR(0)) dut0 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_0), .if_rvalid(if_rvalid_0), .if_rdata(if_rdata_0),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_gnt(dm_gnt_0), .dm_rvalid(dm_rvalid_0), .dm_rdata(dm_rdata_0),
      .mem_req(mem_req_0), .mem_we(mem_we_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0), .mem_be(mem_be_0),
      .mem_ack(mem_ack_0), .mem_rdata(mem_rdata_0), .stall_pc(stall_pc_0), .err_timeout(err_timeout_0)
   );

   // Memory model: ack on the ack_lat-th busy cycle unless no_ack is set.
   always @(negedge clk) begin
      if (mem_req) begin
         bcyc++;
         mem_ack = !no_ack && (bcyc == ack_lat);
      end else begin
         bcyc = 0;
         mem_ack = 1'b0;
      end
      mem_rdata = mem_ack ? rdata_next : 32'h0;
   end

   always @(negedge clk) begin
      mem_ack_0   = mem_req_0 && !mem_ack_0;
      mem_rdata_0 = 32'h0;
   end

   task automatic wait_rv(input bit is_dm, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         #1;
      end while (!(is_dm ? dm_rvalid : if_rvalid) && n < 40);
   endtask

   task automatic test_reset();
      logic [32:0] exp;
      int n;
      dm_req = 1'b1;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_init_mem_req: got %b want 0", mem_req); end
      n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL rst_init_stall: got %b want 0", stall_pc); end
      n_checks++; if ({dm_gnt, if_gnt, dm_rvalid, if_rvalid, err_timeout} !== 5'b0) begin
         n_fail++; $display("FAIL rst_init_pulses: got %b want 00000", {dm_gnt, if_gnt, dm_rvalid, if_rvalid, err_timeout}); end
      @(negedge clk); rst = 1'b0; #1;
      n_checks++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_first_gnt: got %b want 1", dm_gnt); end
      @(negedge clk); dm_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if ({mem_req, stall_pc} !== 2'b11) begin n_fail++; $display("FAIL rst_inflight: got %b want 11", {mem_req, stall_pc}); end
      rst = 1'b1; dm_req = 1'b1; #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_req: got %b want 0", mem_req); end
      n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall_pc); end
      n_checks++; if ({dm_gnt, if_gnt, dm_rvalid, if_rvalid} !== 4'b0) begin
         n_fail++; $display("FAIL rst_mid_pulses: got %b want 0000", {dm_gnt, if_gnt, dm_rvalid, if_rvalid}); end
      @(negedge clk); rst = 1'b0; #1;
      n_checks++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_release_idle_gnt: got %b want 1", dm_gnt); end
      no_ack = 1'b0; ack_lat = 1; rdata_next = 32'h1111_2222;
      q_dm.push_back({1'b0, 32'h1111_2222});
      @(negedge clk); dm_req = 1'b0;
      wait_rv(1'b1, n);
      exp = q_dm.pop_front();
      n_checks++; if (n !== 1) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 1", n); end
      n_checks++; if (dm_rdata !== exp[31:0]) begin n_fail++; $display("FAIL rst_after_rdata: got %h want %h", dm_rdata, exp[31:0]); end
   endtask

   task automatic test_fetch();
      logic [32:0] exp;
      int n;
      ack_lat = 4; rdata_next = 32'h0050_0093;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100; #1;
      n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt: got %b want 1", if_gnt); end
      q_if.push_back({1'b0, 32'h0050_0093});
      @(negedge clk); if_req = 1'b0; #1;
      n_checks++; if ({mem_req, mem_we, mem_be} !== 6'b10_0000) begin
         n_fail++; $display("FAIL fetch_mem_ctl: got %b want 100000", {mem_req, mem_we, mem_be}); end
      n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_mem_addr: got %h want 00000100", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL fetch_mem_wdata: got %h want 0", mem_wdata); end
      wait_rv(1'b0, n);
      exp = q_if.pop_front();
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL fetch_latency: got %0d want 4", n); end
      n_checks++; if (if_rdata !== exp[31:0]) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, exp[31:0]); end
      n_checks++; if ({dm_rvalid, err_timeout} !== {1'b0, exp[32]}) begin
         n_fail++; $display("FAIL fetch_route: got %b want 0%b", {dm_rvalid, err_timeout}, exp[32]); end
      @(negedge clk); #1;
      n_checks++; if (if_rvalid !== 1'b0 || if_rdata !== exp[31:0]) begin
         n_fail++; $display("FAIL fetch_hold: got rvalid %b rdata %h want 0 %h", if_rvalid, if_rdata, exp[31:0]); end
   endtask

   task automatic test_store();
      logic [32:0] exp;
      int n;
      bit stall_ok;
      ack_lat = 2; rdata_next = 32'h1234_5678;
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
      #1;
      n_checks++; if ({dm_gnt, stall_pc} !== 2'b11) begin n_fail++; $display("FAIL store_gnt_stall: got %b want 11", {dm_gnt, stall_pc}); end
      q_dm.push_back({1'b0, 32'h0});
      @(negedge clk); dm_req = 1'b0; #1;
      n_checks++; if ({mem_we, mem_be, stall_pc} !== 6'b1_1111_1) begin
         n_fail++; $display("FAIL store_mem_ctl: got %b want 111111", {mem_we, mem_be, stall_pc}); end
      n_checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2000) begin
         n_fail++; $display("FAIL store_mem_data: got %h@%h want deadbeef@00002000", mem_wdata, mem_addr); end
      stall_ok = 1'b1; n = 0;
      do begin
         @(negedge clk); n++; #1;
         if (!stall_pc) stall_ok = 1'b0;
      end while (!dm_rvalid && n < 40);
      exp = q_dm.pop_front();
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL store_latency: got %0d want 2", n); end
      n_checks++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL store_stall_span: got %b want 1", stall_ok); end
      n_checks++; if (dm_rdata !== exp[31:0]) begin n_fail++; $display("FAIL store_rdata: got %h want %h", dm_rdata, exp[31:0]); end
      @(negedge clk); dm_we = 1'b0; #1;
      n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL store_stall_release: got %b want 0", stall_pc); end
   endtask

   task automatic test_fairness();
      bit q_g1[$];
      bit q_g0[$];
      bit g;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      ack_lat = 1; no_ack = 1'b0; rdata_next = 32'hA5A5_0001;
      q_g1 = '{1'b1, 1'b0, 1'b1, 1'b0};
      q_g0 = '{1'b1, 1'b1, 1'b1, 1'b1};
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
      for (int c = 0; c < 30 && (q_g1.size() != 0 || q_g0.size() != 0); c++) begin
         #1;
         if ((if_gnt || dm_gnt) && q_g1.size() != 0) begin
            g = q_g1.pop_front();
            n_checks++; if ({dm_gnt, if_gnt} !== {g, !g}) begin
               n_fail++; $display("FAIL fair1_order: got dm/if %b want %b", {dm_gnt, if_gnt}, {g, !g}); end
         end
         if ((if_gnt_0 || dm_gnt_0) && q_g0.size() != 0) begin
            g = q_g0.pop_front();
            n_checks++; if ({dm_gnt_0, if_gnt_0} !== {g, !g}) begin
               n_fail++; $display("FAIL fair0_order: got dm/if %b want %b", {dm_gnt_0, if_gnt_0}, {g, !g}); end
         end
         @(negedge clk);
      end
      n_checks++; if (q_g1.size() + q_g0.size() != 0) begin
         n_fail++; $display("FAIL fair_grant_count: got %0d outstanding want 0", q_g1.size() + q_g0.size()); end
      dm_req = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (if_gnt_0 || dm_gnt_0) break;
         @(negedge clk);
      end
      n_checks++; if ({dm_gnt_0, if_gnt_0} !== 2'b01) begin
         n_fail++; $display("FAIL fair0_after_drop: got dm/if %b want 01", {dm_gnt_0, if_gnt_0}); end
      @(negedge clk); if_req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [32:0] exp;
      int n;
      bit err_early;
      no_ack = 1'b1;
      @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; #1;
      n_checks++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL tmo_gnt: got %b want 1", dm_gnt); end
      q_dm.push_back({1'b1, 32'h0});
      @(negedge clk); dm_req = 1'b0; #1;
      n = 0; err_early = 1'b0;
      while (mem_req && n < 40) begin
         n++;
         if (err_timeout) err_early = 1'b1;
         @(negedge clk); #1;
      end
      exp = q_dm.pop_front();
      n_checks++; if (n !== 15) begin n_fail++; $display("FAIL tmo_busy_cycles: got %0d want 15", n); end
      n_checks++; if (err_early !== 1'b0) begin n_fail++; $display("FAIL tmo_early_err: got %b want 0", err_early); end
      n_checks++; if ({dm_rvalid, err_timeout} !== {1'b1, exp[32]}) begin
         n_fail++; $display("FAIL tmo_pulses: got %b want 1%b", {dm_rvalid, err_timeout}, exp[32]); end
      n_checks++; if (dm_rdata !== exp[31:0]) begin n_fail++; $display("FAIL tmo_rdata: got %h want %h", dm_rdata, exp[31:0]); end
      @(negedge clk); #1;
      n_checks++; if ({dm_rvalid, err_timeout} !== 2'b00) begin
         n_fail++; $display("FAIL tmo_pulse_width: got %b want 00", {dm_rvalid, err_timeout}); end
      no_ack = 1'b0; ack_lat = 1; rdata_next = 32'hCAFE_0001;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h400; #1;
      n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL tmo_next_gnt: got %b want 1", if_gnt); end
      q_if.push_back({1'b0, 32'hCAFE_0001});
      @(negedge clk); if_req = 1'b0;
      wait_rv(1'b0, n);
      exp = q_if.pop_front();
      n_checks++; if (n !== 1 || if_rdata !== exp[31:0] || err_timeout !== exp[32]) begin
         n_fail++; $display("FAIL tmo_next_xfer: got lat %0d rdata %h err %b want 1 %h %b", n, if_rdata, err_timeout, exp[31:0], exp[32]); end
   endtask

   task automatic test_ack_at_limit();
      logic [32:0] exp;
      int n;
      bit err_seen;
      ack_lat = 15; no_ack = 1'b0; rdata_next = 32'h0BAD_F00D;
      @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000; #1;
      n_checks++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL lim_gnt: got %b want 1", dm_gnt); end
      q_dm.push_back({1'b0, 32'h0BAD_F00D});
      @(negedge clk); dm_req = 1'b0; #1;
      n = 0; err_seen = 1'b0;
      while (mem_req && n < 40) begin
         n++;
         @(negedge clk); #1;
         if (err_timeout) err_seen = 1'b1;
      end
      exp = q_dm.pop_front();
      n_checks++; if (n !== 15) begin n_fail++; $display("FAIL lim_busy_cycles: got %0d want 15", n); end
      n_checks++; if ({dm_rvalid, err_seen} !== {1'b1, exp[32]}) begin
         n_fail++; $display("FAIL lim_pulses: got rvalid/err %b want 1%b", {dm_rvalid, err_seen}, exp[32]); end
      n_checks++; if (dm_rdata !== exp[31:0]) begin n_fail++; $display("FAIL lim_rdata: got %h want %h", dm_rdata, exp[31:0]); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_fairness();
      test_timeout();
      test_ack_at_limit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
